// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ack byte handshake, framing-error and overrun pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames and add the o_parity_err pulse.
module uart_rx #(
    parameter int CLOCKS_PER_BAUD = 104
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    input  logic       i_ack,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       o_parity_err
`endif
);

    localparam int CW = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'((CLOCKS_PER_BAUD - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      sync_q, sync_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic            parity_bit_q, parity_bit_d;
    logic            parity_err_q, parity_err_d;
`endif
    logic            rx_s;
    logic            cnt_done;

    assign rx_s     = sync_q[1];
    assign cnt_done = (cnt_q == '0);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_done ? cnt_q : cnt_q - CW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        sync_d      = {sync_q[0], i_rx};
        data_d      = data_q;
        valid_d     = valid_q & ~i_ack;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        parity_err_d = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            S_START: begin
                if (cnt_done) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        cnt_d     = FULL_RELOAD;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_done) begin
                    shift_d[bit_idx_q] = rx_s;
                    cnt_d              = FULL_RELOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_done) begin
                    parity_bit_d = rx_s;
                    cnt_d        = FULL_RELOAD;
                    state_d      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_done) begin
                    if (rx_s) begin
                        // An ack in this same cycle frees the slot, so the new byte is no overrun.
                        data_d    = shift_q;
                        valid_d   = 1'b1;
                        overrun_d = valid_q & ~i_ack;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = ^{shift_q, parity_bit_q};
`endif
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (i_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            sync_q      <= 2'b11;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            sync_q      <= sync_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level scoreboard checked every cycle plus directed literal checks.
// Define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx;

    localparam int C = 8;
    localparam int H = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
    localparam int LAT_LIT  = 86;
`else
    localparam int PAR_BITS = 0;
    localparam int LAT_LIT  = 78;
`endif
    // Edges from the cycle the start bit is driven to the edge whose result shows the stop sample.
    localparam int DONE_OFS = 1 + 2 + H + 9 * C + PAR_BITS * C + 1;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx = 1'b1;
    logic       i_ack = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_overrun, o_busy;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    uart_rx #(.CLOCKS_PER_BAUD(C)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .i_ack       (i_ack),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parity_err(o_parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef enum int {K_BYTE, K_FERR} kind_e;
    typedef struct {
        int         edge_no;
        kind_e      kind;
        logic [7:0] data;
        logic       perr;
    } ev_t;

    ev_t  evq[$];
    int   edge_n = 0;
    logic ack_s = 1'b0;
    logic reset_s = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic ack_req = 1'b0;
    logic auto_ack = 1'b0;
    logic collect = 1'b0;
    logic [7:0] rxq[$];
    int   fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    int   rise_edge = -1;

    always @(posedge clk) begin
        edge_n  <= edge_n + 1;
        ack_s   <= i_ack;
        reset_s <= i_reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                              input bit expect_event);
        ev_t ev;
        if (expect_event) begin
            ev.edge_no = edge_n + DONE_OFS;
            ev.kind    = stop_bit ? K_BYTE : K_FERR;
            ev.data    = b;
            ev.perr    = par_flip;
            evq.push_back(ev);
        end
        i_rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            tick(C);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = (^b) ^ par_flip;
        tick(C);
`endif
        i_rx = stop_bit;
        tick(C);
    endtask

    task automatic ack_pulse();
        ack_req = 1'b1;
        tick(1);
        ack_req = 1'b0;
    endtask

    // Consumer: acknowledges on request, or automatically whenever a byte is presented.
    initial forever begin
        @(posedge clk);
        #3;
        i_ack = ack_req || (auto_ack && (o_valid === 1'b1));
    end

    // Event counters and byte collector.
    initial begin : monitor
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (o_frame_err === 1'b1) fe_cnt++;
            if (o_overrun === 1'b1) ov_cnt++;
`ifdef UART_RX_PARITY_EN
            if (o_parity_err === 1'b1) pe_cnt++;
`endif
            if (o_valid === 1'b1 && !prev_valid) begin
                rise_edge = edge_n;
                if (collect) rxq.push_back(o_data);
            end
            prev_valid = (o_valid === 1'b1);
        end
    end

    // Frame-level model: each scheduled event fires on its stop-sample edge; otherwise ack drains the slot.
    initial begin : model
        ev_t  ev;
        bit   seen_reset, got_byte;
        logic exp_valid, exp_fe, exp_ov, exp_pe;
        logic [7:0] exp_data;
        seen_reset = 0;
        exp_valid = 0; exp_fe = 0; exp_ov = 0; exp_pe = 0; exp_data = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_s) begin
                seen_reset = 1;
                exp_valid = 0; exp_fe = 0; exp_ov = 0; exp_pe = 0; exp_data = 8'h00;
                evq.delete();
            end else if (seen_reset) begin
                exp_fe = 0; exp_ov = 0; exp_pe = 0;
                got_byte = 0;
                if (evq.size() > 0 && evq[0].edge_no == edge_n) begin
                    ev = evq.pop_front();
                    if (ev.kind == K_BYTE) begin
                        exp_ov    = exp_valid && !ack_s;
                        exp_valid = 1;
                        exp_data  = ev.data;
                        exp_pe    = ev.perr;
                        got_byte  = 1;
                    end else begin
                        exp_fe = 1;
                    end
                end
                if (!got_byte && exp_valid && ack_s) exp_valid = 0;
            end
            if (seen_reset) begin
                check("model_valid", o_valid, exp_valid);
                check("model_data", o_data, exp_data);
                check("model_frame_err", o_frame_err, exp_fe);
                check("model_overrun", o_overrun, exp_ov);
`ifdef UART_RX_PARITY_EN
                check("model_parity_err", o_parity_err, exp_pe);
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] hello [13];
        logic [7:0] rb;
        int t0, fe0, ov0, pe0;
        bit saw_busy;
        logic [31:0] got;
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                  8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

        // Reset values
        tick(3);
        check("rst_data", o_data, 8'h00);
        check("rst_valid", o_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_frame_err", o_frame_err, 1'b0);
        check("rst_overrun", o_overrun, 1'b0);
        i_reset = 1'b0;
        tick(5);

        // Single byte, no ack: latency, hold, then ack clears
        t0 = edge_n + 1;
        send_frame(8'h48, 1'b1, 1'b0, 1'b1);
        tick(4);
        check("h_latency", rise_edge - t0, LAT_LIT);
        check("h_data", o_data, 8'h48);
        check("h_valid_held", o_valid, 1'b1);
        ack_pulse();
        check("h_valid_cleared", o_valid, 1'b0);

        // Back-to-back message with immediate ack
        tick(5);
        fe0 = fe_cnt; ov0 = ov_cnt;
        rxq.delete();
        auto_ack = 1'b1; collect = 1'b1;
        for (int i = 0; i < 13; i++) send_frame(hello[i], 1'b1, 1'b0, 1'b1);
        tick(2 * C);
        auto_ack = 1'b0; collect = 1'b0;
        check("hello_count", rxq.size(), 13);
        for (int i = 0; i < 13; i++) begin
            got = (i < rxq.size()) ? {24'h0, rxq[i]} : 32'hFFFF_FFFF;
            check($sformatf("hello_byte%0d", i), got, {24'h0, hello[i]});
        end
        check("hello_no_frame_err", fe_cnt - fe0, 0);
        check("hello_no_overrun", ov_cnt - ov0, 0);

        // Overrun: second byte arrives unacknowledged
        ov0 = ov_cnt;
        send_frame(8'h65, 1'b1, 1'b0, 1'b1);
        send_frame(8'h6C, 1'b1, 1'b0, 1'b1);
        tick(4);
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_data", o_data, 8'h6C);
        check("ovr_valid", o_valid, 1'b1);
        ack_pulse();
        check("ovr_valid_cleared", o_valid, 1'b0);

        // Framing error followed by a held-low line, then a clean byte
        tick(5);
        fe0 = fe_cnt;
        send_frame(8'h41, 1'b0, 1'b0, 1'b1);
        tick(40);
        i_rx = 1'b1;
        tick(2 * C);
        check("ferr_pulses", fe_cnt - fe0, 1);
        check("ferr_valid", o_valid, 1'b0);
        check("ferr_busy_released", o_busy, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0, 1'b1);
        tick(4);
        check("after_ferr_data", o_data, 8'h42);
        check("after_ferr_valid", o_valid, 1'b1);
        ack_pulse();

        // Short glitch: treated as a false start
        tick(5);
        i_rx = 1'b0;
        tick(2);
        i_rx = 1'b1;
        saw_busy = 0;
        for (int i = 0; i < C / 2 + 3 - 1; i++) begin
            tick(1);
            if (o_busy === 1'b1) saw_busy = 1;
        end
        check("glitch_busy_seen", saw_busy, 1'b1);
        check("glitch_busy_cleared", o_busy, 1'b0);
        check("glitch_no_valid", o_valid, 1'b0);

        // Reset during data bit 4 abandons the frame
        tick(5);
        rb = 8'hC3;
        i_rx = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            i_rx = rb[i];
            tick(C);
        end
        i_rx = rb[4];
        tick(C / 2);
        i_reset = 1'b1;
        i_rx = 1'b1;
        tick(1);
        check("midrst_data", o_data, 8'h00);
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_busy", o_busy, 1'b0);
        i_reset = 1'b0;
        tick(3 * C);
        check("midrst_idle", o_busy, 1'b0);
        check("midrst_no_valid", o_valid, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        tick(4);
        check("after_rst_data", o_data, 8'h5A);
        check("after_rst_valid", o_valid, 1'b1);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        // Even parity: correct bit, then inverted bit
        tick(5);
        pe0 = pe_cnt;
        send_frame(8'h21, 1'b1, 1'b0, 1'b1);
        tick(4);
        check("par_ok_no_err", pe_cnt - pe0, 0);
        check("par_ok_data", o_data, 8'h21);
        ack_pulse();
        tick(5);
        send_frame(8'h21, 1'b1, 1'b1, 1'b1);
        tick(4);
        check("par_bad_err", pe_cnt - pe0, 1);
        check("par_bad_data", o_data, 8'h21);
        check("par_bad_valid", o_valid, 1'b1);
        ack_pulse();
`else
        pe0 = pe_cnt;
        check("no_parity_pulses", pe_cnt - pe0, 0);
`endif

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
